// File: rtl/vending_change.sv
// Vending controller with configurable price, credit ceiling with coin rejection,
// cancel/refund, and change paid out as one coin pulse per cycle.
//
// state   | meaning
// COLLECT | accepting coins, waiting for price or cancel
// VEND    | drink pulse visible this cycle
// CHANGE  | change pulse visible this cycle; leaves once credit is 0
module vending_change #(
  parameter int PRICE_UNITS = 3,
  parameter int MAX_CREDIT  = 15,
  parameter int CREDIT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                cancel,
  output logic                drink,
  output logic                change5,
  output logic                change10,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W:0]   PRICE = (CREDIT_W+1)'(PRICE_UNITS);
  localparam logic [CREDIT_W:0]   MAXC  = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] ONE   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO   = CREDIT_W'(2);

  state_t              state;
  logic [1:0]          add;
  logic [CREDIT_W:0]   sum;
  logic                coins_in;
  logic                pay10;
  logic [CREDIT_W-1:0] credit_paid;

  assign add         = {1'b0, coin5} + {coin10, 1'b0};
  assign sum         = {1'b0, credit} + (CREDIT_W+1)'(add);
  assign coins_in    = coin5 | coin10;
  // Largest coin first; the state is CHANGE in exactly the cycles a pulse is visible.
  assign pay10       = (credit >= TWO);
  assign credit_paid = credit - (pay10 ? TWO : ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      credit      <= '0;
      drink       <= 1'b0;
      change5     <= 1'b0;
      change10    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      drink       <= 1'b0;
      change5     <= 1'b0;
      change10    <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        COLLECT: begin
          if (cancel && credit != '0) begin
            coin_reject <= coins_in;
            change10    <= pay10;
            change5     <= ~pay10;
            credit      <= credit_paid;
            state       <= CHANGE;
            busy        <= 1'b1;
          end else if (sum > MAXC) begin
            coin_reject <= coins_in;
          end else if (sum >= PRICE) begin
            credit <= sum[CREDIT_W-1:0] - PRICE[CREDIT_W-1:0];
            drink  <= 1'b1;
            state  <= VEND;
            busy   <= 1'b1;
          end else begin
            credit <= sum[CREDIT_W-1:0];
          end
        end
        VEND, CHANGE: begin
          coin_reject <= coins_in;
          if (credit != '0) begin
            change10 <= pay10;
            change5  <= ~pay10;
            credit   <= credit_paid;
            state    <= CHANGE;
            busy     <= 1'b1;
          end else begin
            state <= COLLECT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
